// File: rtl/tlc_junction_ctrl.sv
// Two-road junction lamp sequencer (main/side) with pedestrian walk phase and latched requests.
// Latency: lamps, phase and ped_ack are registered; they change on the clock edge that changes state.
// Backpressure: none; requests are latched until served, and ped_ack flags each newly accepted press.
//
// Ports:
//   clk, rst            - clock (rising edge), asynchronous active-low reset
//   side_req            - side-road vehicle sensor (level)
//   ped_req             - pedestrian button (level or pulse)
//   ped_ack             - one-cycle pulse when a pedestrian request is accepted
//   main_*/side_*       - vehicle lamps, exactly one lit per road
//   walk                - pedestrian walk lamp
//   phase               - current state code (debug)
module tlc_junction_ctrl #(
    parameter int CNT_W  = 4,
    parameter int T_MG   = 10,
    parameter int T_SG   = 6,
    parameter int T_Y    = 3,
    parameter int T_AR   = 2,
    parameter int T_WALK = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       side_req,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic       main_red,
    output logic       main_yellow,
    output logic       main_green,
    output logic       side_red,
    output logic       side_yellow,
    output logic       side_green,
    output logic       walk,
    output logic [2:0] phase
);

    // Every duration must be loadable as (T-1) into the timer.
    localparam int T_MAX = 1 << CNT_W;

    generate
        if (T_MG < 1 || T_MG > T_MAX || T_SG < 1 || T_SG > T_MAX ||
            T_Y < 1 || T_Y > T_MAX || T_AR < 1 || T_AR > T_MAX ||
            T_WALK < 1 || T_WALK > T_MAX) begin : g_bad_timing
            $error("tlc_junction_ctrl: every T_* must be in 1..2**CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] L_MG   = CNT_W'(T_MG - 1);
    localparam logic [CNT_W-1:0] L_SG   = CNT_W'(T_SG - 1);
    localparam logic [CNT_W-1:0] L_Y    = CNT_W'(T_Y - 1);
    localparam logic [CNT_W-1:0] L_AR   = CNT_W'(T_AR - 1);
    localparam logic [CNT_W-1:0] L_WALK = CNT_W'(T_WALK - 1);
    localparam logic [CNT_W-1:0] L_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_MG   = 3'd1,
        S_MY   = 3'd2,
        S_AR_M = 3'd3,
        S_WALK = 3'd4,
        S_SG   = 3'd5,
        S_SY   = 3'd6,
        S_AR_S = 3'd7
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_nxt;
    logic             r_side_pend;
    logic             r_ped_pend;
    logic             r_ped_ack;
    logic             r_main_red, r_main_yellow, r_main_green;
    logic             r_side_red, r_side_yellow, r_side_green;
    logic             r_walk;
    logic             w_expired;
    logic             w_enter_sg;
    logic             w_enter_walk;
    logic             w_ped_set;

    function automatic logic [CNT_W-1:0] dur_m1(input state_t s);
        case (s)
            S_MG:           dur_m1 = L_MG;
            S_SG:           dur_m1 = L_SG;
            S_MY, S_SY:     dur_m1 = L_Y;
            S_WALK:         dur_m1 = L_WALK;
            default:        dur_m1 = L_AR;
        endcase
    endfunction

    assign w_expired = (r_timer == '0);

    always_comb begin
        w_next = r_state;
        if (w_expired) begin
            case (r_state)
                S_INIT: w_next = S_MG;
                S_MG:   if (r_side_pend || r_ped_pend) w_next = S_MY;
                S_MY:   w_next = S_AR_M;
                S_AR_M: w_next = r_ped_pend ? S_WALK : (r_side_pend ? S_SG : S_MG);
                S_WALK: w_next = r_side_pend ? S_SG : S_MG;
                S_SG:   w_next = S_SY;
                S_SY:   w_next = S_AR_S;
                S_AR_S: w_next = r_ped_pend ? S_WALK : S_MG;
                default: w_next = S_INIT;
            endcase
        end
    end

    // Load on any state change; otherwise count down and park at zero
    // (this is what lets MG hold indefinitely with the timer at 0).
    always_comb begin
        w_timer_nxt = r_timer;
        if (w_next != r_state)
            w_timer_nxt = dur_m1(w_next);
        else if (!w_expired)
            w_timer_nxt = r_timer - L_ONE;
    end

    assign w_enter_sg   = (w_next == S_SG)   && (r_state != S_SG);
    assign w_enter_walk = (w_next == S_WALK) && (r_state != S_WALK);
    // A press is accepted when nothing is pending, or on the edge that
    // consumes the pending one: that press is kept for the next round.
    assign w_ped_set    = ped_req && (!r_ped_pend || w_enter_walk);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_INIT;
            r_timer       <= L_AR;
            r_side_pend   <= 1'b0;
            r_ped_pend    <= 1'b0;
            r_ped_ack     <= 1'b0;
            r_main_red    <= 1'b1;
            r_main_yellow <= 1'b0;
            r_main_green  <= 1'b0;
            r_side_red    <= 1'b1;
            r_side_yellow <= 1'b0;
            r_side_green  <= 1'b0;
            r_walk        <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_timer       <= w_timer_nxt;
            r_side_pend   <= side_req || (r_side_pend && !w_enter_sg);
            r_ped_pend    <= w_ped_set || (r_ped_pend && !w_enter_walk);
            r_ped_ack     <= w_ped_set;
            // Lamps decoded from the next state so they line up with r_state.
            r_main_green  <= (w_next == S_MG);
            r_main_yellow <= (w_next == S_MY);
            r_main_red    <= (w_next != S_MG) && (w_next != S_MY);
            r_side_green  <= (w_next == S_SG);
            r_side_yellow <= (w_next == S_SY);
            r_side_red    <= (w_next != S_SG) && (w_next != S_SY);
            r_walk        <= (w_next == S_WALK);
        end
    end

    assign ped_ack     = r_ped_ack;
    assign main_red    = r_main_red;
    assign main_yellow = r_main_yellow;
    assign main_green  = r_main_green;
    assign side_red    = r_side_red;
    assign side_yellow = r_side_yellow;
    assign side_green  = r_side_green;
    assign walk        = r_walk;
    assign phase       = r_state;

endmodule

// File: tb/tb_tlc_junction_ctrl.sv
// Directed bench for the junction controller: segment table of {inputs, expected phase/ack}.
// Latency: one row cycle per clock; outputs sampled on the falling edge.
// Backpressure: n/a; reset rows exercise asynchronous reset mid-sequence.
module tb_tlc_junction_ctrl;

    localparam logic [2:0] P_INIT = 3'd0, P_MG = 3'd1, P_MY = 3'd2, P_AR_M = 3'd3,
                           P_WALK = 3'd4, P_SG = 3'd5, P_SY = 3'd6, P_AR_S = 3'd7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       side_req = 1'b0;
    logic       ped_req = 1'b0;
    logic       ped_ack;
    logic       main_red, main_yellow, main_green;
    logic       side_red, side_yellow, side_green;
    logic       walk;
    logic [2:0] phase;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tlc_junction_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .side_req   (side_req),
        .ped_req    (ped_req),
        .ped_ack    (ped_ack),
        .main_red   (main_red),
        .main_yellow(main_yellow),
        .main_green (main_green),
        .side_red   (side_red),
        .side_yellow(side_yellow),
        .side_green (side_green),
        .walk       (walk),
        .phase      (phase)
    );

    typedef struct {
        logic       do_rst;   // pulse reset before this row, restart cycle count
        int         ncyc;     // number of cycles this row covers
        logic       side;
        logic       ped;
        logic [2:0] ph;       // expected phase during these cycles
        logic       ack;      // expected ped_ack during these cycles
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input int n, input logic s, input logic p,
                                input logic [2:0] ph, input logic a);
        vec_t v;
        v.do_rst = r; v.ncyc = n; v.side = s; v.ped = p; v.ph = ph; v.ack = a;
        tbl.push_back(v);
    endfunction

    // {main_red, main_yellow, main_green, side_red, side_yellow, side_green, walk}
    function automatic logic [6:0] exp_lamps(input logic [2:0] ph);
        case (ph)
            P_MG:    exp_lamps = 7'b001_100_0;
            P_MY:    exp_lamps = 7'b010_100_0;
            P_SG:    exp_lamps = 7'b100_001_0;
            P_SY:    exp_lamps = 7'b100_010_0;
            P_WALK:  exp_lamps = 7'b100_100_1;
            default: exp_lamps = 7'b100_100_0;
        endcase
    endfunction

    function automatic logic [6:0] act_lamps();
        act_lamps = {main_red, main_yellow, main_green, side_red, side_yellow, side_green, walk};
    endfunction

    task automatic chk(input string name, input int cyc, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_cycle(input int cyc, input logic [2:0] ph, input logic ack);
        logic ok;
        chk("phase", cyc, {5'b0, phase}, {5'b0, ph});
        chk("lamps", cyc, {1'b0, act_lamps()}, {1'b0, exp_lamps(ph)});
        chk("ped_ack", cyc, {7'b0, ped_ack}, {7'b0, ack});
        ok = ($countones({main_red, main_yellow, main_green}) == 1) &&
             ($countones({side_red, side_yellow, side_green}) == 1) &&
             !(walk && (main_green || main_yellow || side_green || side_yellow));
        chk("safety", cyc, {7'b0, ok}, 8'd1);
    endtask

    // Called right after a falling edge; leaves the bench at a falling edge = cycle 0.
    task automatic do_reset();
        #2 rst = 1'b0;
        side_req = 1'b0;
        ped_req  = 1'b0;
        #1;
        chk("async_rst_phase", -1, {5'b0, phase}, {5'b0, P_INIT});
        chk("async_rst_lamps", -1, {1'b0, act_lamps()}, 8'b0_100_100_0);
        chk("async_rst_ack", -1, {7'b0, ped_ack}, 8'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int cyc;

        // 1: idle after reset - INIT 2 cycles, then MG held.
        add(1, 2, 0, 0, P_INIT, 0);
        add(0, 38, 0, 0, P_MG, 0);

        // 2: side_req pulse at cycle 5 - full side cycle, back to MG at 28, no re-service.
        add(1, 2, 0, 0, P_INIT, 0);
        add(0, 3, 0, 0, P_MG, 0);
        add(0, 1, 1, 0, P_MG, 0);
        add(0, 6, 0, 0, P_MG, 0);
        add(0, 3, 0, 0, P_MY, 0);
        add(0, 2, 0, 0, P_AR_M, 0);
        add(0, 6, 0, 0, P_SG, 0);
        add(0, 3, 0, 0, P_SY, 0);
        add(0, 2, 0, 0, P_AR_S, 0);
        add(0, 13, 0, 0, P_MG, 0);

        // 3: ped_req held cycles 4-8 - single ack at 5, WALK 17-21, then MG.
        add(1, 2, 0, 0, P_INIT, 0);
        add(0, 2, 0, 0, P_MG, 0);
        add(0, 1, 0, 1, P_MG, 0);
        add(0, 1, 0, 1, P_MG, 1);
        add(0, 3, 0, 1, P_MG, 0);
        add(0, 3, 0, 0, P_MG, 0);
        add(0, 3, 0, 0, P_MY, 0);
        add(0, 2, 0, 0, P_AR_M, 0);
        add(0, 5, 0, 0, P_WALK, 0);
        add(0, 13, 0, 0, P_MG, 0);

        // 4: both requests at cycle 3 - WALK first, then SG, both latches cleared.
        add(1, 2, 0, 0, P_INIT, 0);
        add(0, 1, 0, 0, P_MG, 0);
        add(0, 1, 1, 1, P_MG, 0);
        add(0, 1, 0, 0, P_MG, 1);
        add(0, 7, 0, 0, P_MG, 0);
        add(0, 3, 0, 0, P_MY, 0);
        add(0, 2, 0, 0, P_AR_M, 0);
        add(0, 5, 0, 0, P_WALK, 0);
        add(0, 6, 0, 0, P_SG, 0);
        add(0, 3, 0, 0, P_SY, 0);
        add(0, 2, 0, 0, P_AR_S, 0);
        add(0, 13, 0, 0, P_MG, 0);

        // 5: ped press on the edge entering WALK - second ack, second WALK after next round.
        add(1, 2, 0, 0, P_INIT, 0);
        add(0, 1, 0, 0, P_MG, 0);
        add(0, 1, 0, 1, P_MG, 0);
        add(0, 1, 0, 0, P_MG, 1);
        add(0, 7, 0, 0, P_MG, 0);
        add(0, 3, 0, 0, P_MY, 0);
        add(0, 1, 0, 0, P_AR_M, 0);
        add(0, 1, 0, 1, P_AR_M, 0);
        add(0, 1, 0, 0, P_WALK, 1);
        add(0, 4, 0, 0, P_WALK, 0);
        add(0, 10, 0, 0, P_MG, 0);
        add(0, 3, 0, 0, P_MY, 0);
        add(0, 2, 0, 0, P_AR_M, 0);
        add(0, 5, 0, 0, P_WALK, 0);
        add(0, 13, 0, 0, P_MG, 0);

        // 6: reset mid-SG - async return to reset values, pending side request discarded.
        add(1, 2, 0, 0, P_INIT, 0);
        add(0, 1, 0, 0, P_MG, 0);
        add(0, 1, 1, 0, P_MG, 0);
        add(0, 8, 0, 0, P_MG, 0);
        add(0, 3, 0, 0, P_MY, 0);
        add(0, 2, 0, 0, P_AR_M, 0);
        add(0, 3, 1, 0, P_SG, 0);   // side_req still up so side_pend is set at reset time
        add(1, 2, 0, 0, P_INIT, 0);
        add(0, 20, 0, 0, P_MG, 0);

        @(negedge clk);
        cyc = 0;
        foreach (tbl[i]) begin
            if (tbl[i].do_rst) begin
                do_reset();
                cyc = 0;
            end
            for (int k = 0; k < tbl[i].ncyc; k++) begin
                check_cycle(cyc, tbl[i].ph, tbl[i].ack);
                side_req = tbl[i].side;
                ped_req  = tbl[i].ped;
                @(negedge clk);
                cyc++;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tlc_junction_ctrl.md
Name: tlc_junction_ctrl

Overview:
- Two-road junction controller (main road, side road) with a pedestrian crossing phase.
- Sequences a single internal down-counter timer shared across all phases.
- Drives both sets of vehicle lamps plus the walk lamp.
- Takes side-road and pedestrian requests through latched request logic and a request/acknowledge handshake.
- Sits at the same level as the single-road controller/datapath pair: a self-contained top-level lamp sequencer.

Parameters:
- CNT_W, 4, timer width in bits.
- T_MG, 10, minimum main-green duration in cycles.
- T_SG, 6, side-green duration in cycles.
- T_Y, 3, yellow duration in cycles, both roads.
- T_AR, 2, all-red clearance duration in cycles.
- T_WALK, 5, pedestrian walk duration in cycles.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- side_req  input  1  side-road vehicle sensor, level.
- ped_req  input  1  pedestrian button, level or pulse.
- ped_ack  output  1  one-cycle pulse: pedestrian request accepted.
- main_red  output  1  main-road red lamp.
- main_yellow  output  1  main-road yellow lamp.
- main_green  output  1  main-road green lamp.
- side_red  output  1  side-road red lamp.
- side_yellow  output  1  side-road yellow lamp.
- side_green  output  1  side-road green lamp.
- walk  output  1  pedestrian walk lamp.
- phase  output  3  current state encoding, for debug and verification.

Behaviour:
- Reset and clocking:
  - One clock; rst is asynchronous and active-low.
  - On reset: state INIT (phase=0), timer=T_AR-1, side_pend=0, ped_pend=0, ped_ack=0.
  - Reset lamp values: main_red=1, side_red=1, every other lamp 0, walk=0.
- States and phase codes: INIT=0, MG=1, MY=2, AR_M=3, WALK=4, SG=5, SY=6, AR_S=7.
- Lamps are a Moore decode of the state:
  - MG: main_green.
  - MY: main_yellow.
  - SG: side_green.
  - SY: side_yellow.
  - WALK: walk=1.
  - Whichever road has no lamp lit above shows red. INIT, AR_M, AR_S and WALK are all-red.
  - Exactly one lamp per road is lit in every cycle.
- Timer:
  - On every state transition, load the new state's duration minus 1.
  - Otherwise decrement, saturating at 0.
  - "expired" = timer==0. Every timed state therefore lasts exactly its T cycles.
- Transitions, evaluated at the clock edge:
  - INIT -> MG when expired.
  - MG -> MY when expired and (side_pend or ped_pend). Otherwise hold MG indefinitely with the timer held at 0.
  - MY -> AR_M when expired.
  - AR_M -> WALK if ped_pend, else SG if side_pend, else MG, when expired.
  - WALK -> SG if side_pend, else MG, when expired.
  - SG -> SY when expired.
  - SY -> AR_S when expired.
  - AR_S -> WALK if ped_pend, else MG, when expired.
- Request latches:
  - side_pend sets on any cycle with side_req=1 and clears on the transition into SG.
  - ped_pend sets on a cycle with ped_req=1 and ped_pend=0, and clears on the transition into WALK.
  - For both latches, set wins over clear in the same cycle: a request arriving on the entry edge is held for the next round.
- ped_ack:
  - Registered; high exactly one cycle after the cycle where ped_pend goes 0->1.
  - A held or repeated ped_req while ped_pend=1 produces no further ack.
- Reset mid-operation: immediate return to the reset values above, regardless of state or timer; pending requests are discarded.
- Width rule: every T_* must be >=1 and <=2^CNT_W. An illegal setting is an elaboration error, enforced by a generate-time check.
- Safety invariant: main_green/main_yellow and side_green/side_yellow are never both active. walk never overlaps any green or yellow.

Test Plan:
- Reset, then no requests for 40 cycles -> INIT for 2 cycles, then MG held from cycle 2 onward; side_red=1 throughout; ped_ack never pulses.
- side_req pulsed 1 cycle at cycle 5 -> MG ends at cycle 12 (INIT 2 + T_MG 10). Then MY 3 cycles, AR_M 2, SG 6, SY 3, AR_S 2, then back to MG at cycle 28; side_pend=0 after SG entry.
- ped_req high cycles 4-8 -> ped_ack high only at cycle 5. Sequence is MG to cycle 12, MY, AR_M, then WALK for 5 cycles with walk=1 and all red, then MG.
- side_req and ped_req both asserted during MG -> order is AR_M -> WALK -> SG -> SY -> AR_S -> MG; both pend flags clear.
- ped_req asserted on the exact edge entering WALK -> the current WALK completes; a second ped_ack pulse occurs; a second WALK is served after the next AR phase.
- rst asserted low during SG mid-count -> outputs reach reset values asynchronously, before the next clk edge; after release, INIT for 2 cycles, then MG.
- All scenarios -> assertion checker confirms the safety invariant and exactly one lamp per road on every cycle.
